// File: rtl/carbon_uart_tx_phy.sv
// carbon_uart_tx_phy: 8N1 UART transmitter with a small byte FIFO.
// Back-to-back frames leave the stop bit straight into the next start bit.
module carbon_uart_tx_phy #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tx_valid,
  input  logic [7:0]                  tx_data,
  output logic                        tx_ready,
  output logic                        txd,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = PW + 1;
  localparam int CNTW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0]   FULL    = CW'(FIFO_DEPTH);
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("CLKS_PER_BIT must be >= 2");
  end

  if (FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [CNTW-1:0] cnt_q;
  logic [CNTW-1:0] cnt_d;
  logic [2:0]      idx_q;
  logic [2:0]      idx_d;
  logic [7:0]      sh_q;
  logic [7:0]      sh_d;
  logic            txd_q;
  logic            txd_d;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;

  logic       push;
  logic       pop;
  logic       have;
  logic       cnt_end;
  logic [7:0] head;

  assign tx_ready   = (count_q != FULL);
  assign push       = tx_valid && tx_ready;
  assign have       = (count_q != '0);
  assign head       = mem[rd_ptr];
  assign cnt_end    = (cnt_q == '0);
  assign txd        = txd_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != IDLE) || have;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    txd_d   = txd_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (have) begin
          pop     = 1'b1;
          sh_d    = head;
          txd_d   = 1'b0;
          cnt_d   = CNT_MAX;
          state_d = START;
        end
      end
      START: begin
        if (cnt_end) begin
          state_d = DATA;
          idx_d   = 3'd0;
          cnt_d   = CNT_MAX;
          txd_d   = sh_q[0];
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      DATA: begin
        if (!cnt_end) begin
          cnt_d = cnt_q - CNTW'(1);
        end else if (idx_q == 3'd7) begin
          state_d = STOP;
          cnt_d   = CNT_MAX;
          txd_d   = 1'b1;
        end else begin
          // sh_q[0] is the bit on the line; bit 1 goes next
          idx_d = idx_q + 3'd1;
          sh_d  = sh_q >> 1;
          txd_d = sh_q[1];
          cnt_d = CNT_MAX;
        end
      end
      STOP: begin
        if (!cnt_end) begin
          cnt_d = cnt_q - CNTW'(1);
        end else if (have) begin
          pop     = 1'b1;
          sh_d    = head;
          txd_d   = 1'b0;
          cnt_d   = CNT_MAX;
          state_d = START;
        end else begin
          state_d = IDLE;
          txd_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      txd_q   <= txd_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // storage needs no reset: pointers define what is valid
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

endmodule

// File: tb/tb_carbon_uart_tx_phy.sv
// tb_carbon_uart_tx_phy: randomized and directed bench against an
// edge-indexed frame model of the UART transmitter.
module tb_carbon_uart_tx_phy;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FL    = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       txd;
  logic       busy;
  logic [2:0] fifo_count;

  carbon_uart_tx_phy #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .txd       (txd),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int chk = 0;
  int err = 0;

  // model: e = index of the next edge, p = edge of the last pop
  int         e;
  int         p;
  logic [7:0] cur;
  logic [7:0] dec;
  logic [7:0] q[$];
  logic [7:0] sent_q[$];
  logic [7:0] rx_q[$];
  logic       acc;
  logic [5:0] exp_o;

  function automatic logic [5:0] obs();
    return {txd, busy, tx_ready, fifo_count};
  endfunction

  function automatic bit m_idle();
    return q.size() == 0 && e >= p + FL;
  endfunction

  function automatic int order_diffs();
    int d;
    int m;
    m = (rx_q.size() < sent_q.size()) ? rx_q.size() : sent_q.size();
    d = rx_q.size() - sent_q.size();
    if (d < 0) d = -d;
    for (int i = 0; i < m; i++)
      if (rx_q[i] !== sent_q[i]) d++;
    return d;
  endfunction

  task automatic model_reset();
    q.delete();
    sent_q.delete();
    rx_q.delete();
    p = -1000000;
  endtask

  // drive one edge and advance the frame model; leaves exp_o set
  task automatic step(input logic v, input logic [7:0] d);
    int   pre;
    int   j;
    int   sl;
    logic po;
    logic et;
    tx_valid = v;
    tx_data  = d;
    @(posedge clk);
    pre = q.size();
    acc = v && pre < DEPTH;
    po  = pre > 0 && e >= p + FL;
    if (po) begin
      cur = q.pop_front();
      p   = e;
    end
    if (acc) begin
      q.push_back(d);
      sent_q.push_back(d);
    end
    #1;
    j  = e - p;
    sl = 0;
    et = 1'b1;
    if (j < FL) begin
      sl = j / CPB;
      if (sl == 0) et = 1'b0;
      else if (sl <= 8) et = cur[sl-1];
      if (j % CPB == CPB / 2 && sl >= 1 && sl <= 8)
        dec[sl-1] = txd;
      if (j == 9 * CPB + CPB / 2) rx_q.push_back(dec);
    end
    exp_o = {et, (j < FL) || q.size() != 0,
             q.size() != DEPTH, 3'(q.size())};
    e++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk++;
    if (obs() !== 6'b101_000) begin
      err++;
      $display("FAIL reset_async got %b exp %b", obs(), 6'b101_000);
    end
    tx_valid = 1'b1;
    tx_data  = 8'hAA;
    @(posedge clk);
    #1;
    chk++;
    if (obs() !== 6'b101_000) begin
      err++;
      $display("FAIL reset_hold got %b exp %b", obs(), 6'b101_000);
    end
    tx_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    e = 0;
    model_reset();
  endtask

  task automatic test_single();
    model_reset();
    step(1'b1, 8'h55);
    chk++;
    if (obs() !== exp_o) begin
      err++;
      $display("FAIL single e=%0d got %b exp %b", e, obs(), exp_o);
    end
    repeat (45) begin
      step(1'b0, 8'h00);
      chk++;
      if (obs() !== exp_o) begin
        err++;
        $display("FAIL single e=%0d got %b exp %b", e, obs(), exp_o);
      end
    end
    chk++;
    if (rx_q.size() != 1 || order_diffs() != 0) begin
      err++;
      $display("FAIL single_rx got %0d bytes exp 1", rx_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int n;
    model_reset();
    step(1'b1, 8'h00);
    step(1'b1, 8'hFF);
    n = 0;
    while (!m_idle() && n < 200) begin
      step(1'b0, 8'h00);
      n++;
      chk++;
      if (obs() !== exp_o) begin
        err++;
        $display("FAIL b2b e=%0d got %b exp %b", e, obs(), exp_o);
      end
    end
    chk++;
    if (rx_q.size() != 2 || order_diffs() != 0) begin
      err++;
      $display("FAIL b2b_rx got %0d bytes exp 2 diffs %0d",
               rx_q.size(), order_diffs());
    end
  endtask

  task automatic test_full();
    logic [7:0] b [6];
    int k;
    int n;
    model_reset();
    b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 8'h66};
    k = 0;
    n = 0;
    while (k < 6 && n < 300) begin
      step(1'b1, b[k]);
      if (acc) k++;
      n++;
      chk++;
      if (obs() !== exp_o) begin
        err++;
        $display("FAIL full e=%0d got %b exp %b", e, obs(), exp_o);
      end
    end
    chk++;
    if (k != 6) begin
      err++;
      $display("FAIL full_accept got %0d bytes exp 6", k);
    end
    n = 0;
    while (!m_idle() && n < 400) begin
      step(1'b0, 8'h00);
      n++;
      chk++;
      if (obs() !== exp_o) begin
        err++;
        $display("FAIL full e=%0d got %b exp %b", e, obs(), exp_o);
      end
    end
    chk++;
    if (rx_q.size() != 6 || order_diffs() != 0) begin
      err++;
      $display("FAIL full_rx got %0d bytes exp 6 diffs %0d",
               rx_q.size(), order_diffs());
    end
  endtask

  task automatic test_same_edge();
    int n;
    model_reset();
    step(1'b1, 8'hC1);
    step(1'b1, 8'hC2);
    step(1'b1, 8'hC3);
    n = 0;
    while (e != p + FL && n < 100) begin
      step(1'b0, 8'h00);
      n++;
      chk++;
      if (obs() !== exp_o) begin
        err++;
        $display("FAIL same e=%0d got %b exp %b", e, obs(), exp_o);
      end
    end
    step(1'b1, 8'hC4);
    chk++;
    if (fifo_count !== 3'd2 || obs() !== exp_o) begin
      err++;
      $display("FAIL same_edge got %b exp %b", obs(), exp_o);
    end
    n = 0;
    while (!m_idle() && n < 300) begin
      step(1'b0, 8'h00);
      n++;
      chk++;
      if (obs() !== exp_o) begin
        err++;
        $display("FAIL same e=%0d got %b exp %b", e, obs(), exp_o);
      end
    end
    chk++;
    if (rx_q.size() != 4 || order_diffs() != 0) begin
      err++;
      $display("FAIL same_rx got %0d bytes exp 4 diffs %0d",
               rx_q.size(), order_diffs());
    end
  endtask

  task automatic test_mid_reset();
    int n;
    model_reset();
    step(1'b1, 8'hA5);
    step(1'b1, 8'h3C);
    step(1'b1, 8'hC3);
    while (e - 1 - p < 17) begin
      step(1'b0, 8'h00);
      chk++;
      if (obs() !== exp_o) begin
        err++;
        $display("FAIL mid e=%0d got %b exp %b", e, obs(), exp_o);
      end
    end
    #2 rst = 1'b1;
    #1;
    chk++;
    if (obs() !== 6'b101_000) begin
      err++;
      $display("FAIL mid_reset got %b exp %b", obs(), 6'b101_000);
    end
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (50) begin
      step(1'b0, 8'h00);
      chk++;
      if (obs() !== exp_o) begin
        err++;
        $display("FAIL mid_quiet e=%0d got %b exp %b", e, obs(), exp_o);
      end
    end
    chk++;
    if (rx_q.size() != 0) begin
      err++;
      $display("FAIL mid_noframe got %0d bytes exp 0", rx_q.size());
    end
    step(1'b1, 8'h96);
    n = 0;
    while (!m_idle() && n < 100) begin
      step(1'b0, 8'h00);
      n++;
      chk++;
      if (obs() !== exp_o) begin
        err++;
        $display("FAIL mid_new e=%0d got %b exp %b", e, obs(), exp_o);
      end
    end
    chk++;
    if (rx_q.size() != 1 || order_diffs() != 0) begin
      err++;
      $display("FAIL mid_rx got %0d bytes exp 1", rx_q.size());
    end
  endtask

  task automatic test_random();
    int   n;
    logic v;
    model_reset();
    n = 0;
    while (sent_q.size() < 1000 && n < 70000) begin
      v = ((n / 400) % 8 != 7) && ($urandom_range(0, 3) == 0);
      step(v, 8'($urandom));
      n++;
      chk++;
      if (obs() !== exp_o) begin
        err++;
        $display("FAIL rand e=%0d got %b exp %b", e, obs(), exp_o);
      end
    end
    chk++;
    if (sent_q.size() < 1000) begin
      err++;
      $display("FAIL rand_accept got %0d bytes exp 1000", sent_q.size());
    end
    n = 0;
    while (!m_idle() && n < 400) begin
      step(1'b0, 8'h00);
      n++;
      chk++;
      if (obs() !== exp_o) begin
        err++;
        $display("FAIL rand e=%0d got %b exp %b", e, obs(), exp_o);
      end
    end
    chk++;
    if (order_diffs() != 0) begin
      err++;
      $display("FAIL rand_order got %0d rx exp %0d diffs %0d",
               rx_q.size(), sent_q.size(), order_diffs());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_same_edge();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
